// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the core's memwrite/dataadr/writedata bus.
// Loads take RD_LAT cycles (stall high for RD_LAT cycles, then one RESP
// cycle with registered readdata). Stores commit in a single cycle. A single
// word at MMIO_ADDR acts as a sticky "done" mailbox. Alignment and protocol
// violations set a sticky err flag.
module dmem_wait_responder #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned RD_LAT    = 2,
   parameter logic [31:0] MMIO_ADDR = 32'd84
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        done_flag,
   output logic [31:0] done_value,
   output logic        err
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] mem [DEPTH];

   logic [31:0] sel_addr;
   logic [31:0] rd_val;
   logic        misalign;
   logic        is_mmio;
   logic        in_range;
   logic        ram_we;

   // Loads read the address latched in IDLE; RD_LAT=1 reads the live bus
   // address on the IDLE edge, which is the same value.
   assign sel_addr = (state == IDLE) ? dataadr : addr_q;

   assign misalign = (dataadr[1:0] != 2'b00);
   assign is_mmio  = (dataadr == MMIO_ADDR);
   assign in_range = (dataadr[31:2] < 30'(DEPTH));
   assign ram_we   = reset && (state == IDLE) && memwrite && !misalign
                     && !is_mmio && in_range;

   // Stall is combinational so the core freezes in the request cycle itself;
   // it is forced low while reset is held.
   assign stall = reset && ((state == WAIT) ||
                            ((state == IDLE) && memread && !memwrite));

   // Address decode for the load data: mailbox first, then RAM, else zero.
   always_comb begin
      rd_val = '0;
      if (sel_addr[1:0] == 2'b00) begin
         if (sel_addr == MMIO_ADDR)
            rd_val = done_value;
         else if (sel_addr[31:2] < 30'(DEPTH))
            rd_val = mem[sel_addr[AW+1:2]];
      end
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (ram_we)
         mem[dataadr[AW+1:2]] <= writedata;
   end

   // Request FSM with registered readdata, mailbox and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_q     <= '0;
         readdata   <= '0;
         done_flag  <= 1'b0;
         done_value <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (memwrite) begin
                  // A store wins over a simultaneous load; the load is dropped.
                  if (is_mmio) begin
                     done_flag  <= 1'b1;
                     done_value <= writedata;
                  end
                  if (memread || misalign)
                     err <= 1'b1;
               end else if (memread) begin
                  addr_q <= dataadr;
                  cnt    <= CNT_INIT;
                  if (misalign)
                     err <= 1'b1;
                  if (RD_LAT == 1) begin
                     readdata <= rd_val;
                     state    <= RESP;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (memwrite)
                  err <= 1'b1;
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  readdata <= rd_val;
                  state    <= RESP;
               end
            end
            RESP: begin
               if (memwrite)
                  err <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: one RD_LAT=2 instance and one RD_LAT=1
// instance, each with its own request bus and reset.
module tb_dmem_wait_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst       = 2'b00;
   logic [1:0]       memread   = '0;
   logic [1:0]       memwrite  = '0;
   logic [1:0][31:0] dataadr   = '0;
   logic [1:0][31:0] writedata = '0;
   logic [31:0]      readdata0, readdata1, done_value0, done_value1;
   logic             stall0, stall1, done_flag0, done_flag1, err0, err1;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   dmem_wait_responder #(.DEPTH(64), .RD_LAT(2), .MMIO_ADDR(32'd84)) u0 (
      .clk(clk), .reset(rst[0]), .memread(memread[0]), .memwrite(memwrite[0]),
      .dataadr(dataadr[0]), .writedata(writedata[0]), .readdata(readdata0),
      .stall(stall0), .done_flag(done_flag0), .done_value(done_value0), .err(err0)
   );

   dmem_wait_responder #(.DEPTH(64), .RD_LAT(1), .MMIO_ADDR(32'd84)) u1 (
      .clk(clk), .reset(rst[1]), .memread(memread[1]), .memwrite(memwrite[1]),
      .dataadr(dataadr[1]), .writedata(writedata[1]), .readdata(readdata1),
      .stall(stall1), .done_flag(done_flag1), .done_value(done_value1), .err(err1)
   );

   function automatic logic [31:0] f_rd(int d);
      return (d == 0) ? readdata0 : readdata1;
   endfunction
   function automatic logic f_stall(int d);
      return (d == 0) ? stall0 : stall1;
   endfunction
   function automatic logic f_err(int d);
      return (d == 0) ? err0 : err1;
   endfunction
   function automatic logic f_done(int d);
      return (d == 0) ? done_flag0 : done_flag1;
   endfunction
   function automatic logic [31:0] f_dval(int d);
      return (d == 0) ? done_value0 : done_value1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk);
      #1;
      memread[d]   = rd;
      memwrite[d]  = wr;
      dataadr[d]   = a;
      writedata[d] = wd;
   endtask

   task automatic idle(input int d);
      drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   // Store cycle, then one idle cycle so sticky outputs are visible.
   task automatic do_store(input int d, input logic [31:0] a, input logic [31:0] wd);
      drive(d, 1'b0, 1'b1, a, wd);
      @(negedge clk);
      chk($sformatf("st%0d_%0d_stall", d, a), {31'd0, f_stall(d)}, 32'd0);
      idle(d);
      @(negedge clk);
   endtask

   // Load with scoreboard: expectation queued at request, popped at RESP.
   task automatic do_load(input int d, input logic [31:0] a, input int lat,
                          input logic [31:0] expv, input string nm);
      int  n;
      bit  got;
      n   = 0;
      got = 1'b0;
      drive(d, 1'b1, 1'b0, a, 32'd0);
      exp_q.push_back(expv);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (f_stall(d)) n++;
         else begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
      else chk({nm, "_lat"}, n, lat);
      chk({nm, "_data"}, f_rd(d), exp_q.pop_front());
   endtask

   task automatic pulse_reset(input int d);
      @(negedge clk);
      rst[d] = 1'b0;
      #2;
      rst[d] = 1'b1;
      @(negedge clk);
      chk("rstpulse_err", {31'd0, f_err(d)}, 32'd0);
      chk("rstpulse_done", {31'd0, f_done(d)}, 32'd0);
   endtask

   typedef struct {
      bit          ld;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        e_err;
      logic        e_done;
      logic [31:0] e_dval;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b0, 32'd8,   32'd7,          32'd0,          1'b0, 1'b0, 32'd0};
      tbl[1]  = '{1'b1, 32'd8,   32'd0,          32'd7,          1'b0, 1'b0, 32'd0};
      tbl[2]  = '{1'b0, 32'd84,  32'd7,          32'd0,          1'b0, 1'b1, 32'd7};
      tbl[3]  = '{1'b1, 32'd84,  32'd0,          32'd7,          1'b0, 1'b1, 32'd7};
      tbl[4]  = '{1'b0, 32'd80,  32'd5,          32'd0,          1'b0, 1'b1, 32'd7};
      tbl[5]  = '{1'b1, 32'd80,  32'd0,          32'd5,          1'b0, 1'b1, 32'd7};
      tbl[6]  = '{1'b0, 32'd144, 32'h11,         32'd0,          1'b0, 1'b1, 32'd7};
      tbl[7]  = '{1'b0, 32'd400, 32'd3,          32'd0,          1'b0, 1'b1, 32'd7};
      tbl[8]  = '{1'b1, 32'd400, 32'd0,          32'd0,          1'b0, 1'b1, 32'd7};
      tbl[9]  = '{1'b1, 32'd144, 32'd0,          32'h11,         1'b0, 1'b1, 32'd7};
      tbl[10] = '{1'b0, 32'd4,   32'hA5A5A5A5,   32'd0,          1'b0, 1'b1, 32'd7};
      tbl[11] = '{1'b0, 32'd6,   32'h12345678,   32'd0,          1'b1, 1'b1, 32'd7};
      tbl[12] = '{1'b1, 32'd4,   32'd0,          32'hA5A5A5A5,   1'b1, 1'b1, 32'd7};
      tbl[13] = '{1'b1, 32'd6,   32'd0,          32'd0,          1'b1, 1'b1, 32'd7};

      // Reset release at 22 ns; all outputs cleared on both instances.
      #22;
      rst = 2'b11;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d_stall", d), {31'd0, f_stall(d)}, 32'd0);
         chk($sformatf("rst%0d_rd", d), f_rd(d), 32'd0);
         chk($sformatf("rst%0d_done", d), {31'd0, f_done(d)}, 32'd0);
         chk($sformatf("rst%0d_dval", d), f_dval(d), 32'd0);
         chk($sformatf("rst%0d_err", d), {31'd0, f_err(d)}, 32'd0);
      end

      // Reset asserted mid-WAIT abandons the read.
      drive(0, 1'b1, 1'b0, 32'd8, 32'd0);
      @(negedge clk);
      chk("mw_idle_stall", {31'd0, stall0}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("mw_wait_stall", {31'd0, stall0}, 32'd1);
      #1;
      rst[0] = 1'b0;
      #1;
      chk("mw_rst_stall", {31'd0, stall0}, 32'd0);
      chk("mw_rst_rd", readdata0, 32'd0);
      memread[0] = 1'b0;
      @(posedge clk);
      #1;
      rst[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mw_after_stall", {31'd0, stall0}, 32'd0);
         chk("mw_after_rd", readdata0, 32'd0);
      end

      // Simultaneous read and write: store performed, read dropped, err set.
      drive(0, 1'b1, 1'b1, 32'd12, 32'd9);
      @(negedge clk);
      chk("simul_stall", {31'd0, stall0}, 32'd0);
      idle(0);
      @(negedge clk);
      chk("simul_err", {31'd0, err0}, 32'd1);
      chk("simul_norsp_stall", {31'd0, stall0}, 32'd0);
      do_load(0, 32'd12, 2, 32'd9, "simul_ld");
      do_store(0, 32'd16, 32'h16);
      pulse_reset(0);

      // Store during WAIT is ignored and flagged; address change is ignored.
      drive(0, 1'b1, 1'b0, 32'd12, 32'd0);
      @(negedge clk);
      chk("wst_idle_stall", {31'd0, stall0}, 32'd1);
      @(posedge clk);
      #1;
      memwrite[0]  = 1'b1;
      dataadr[0]   = 32'd16;
      writedata[0] = 32'hDEAD;
      @(negedge clk);
      chk("wst_wait_stall", {31'd0, stall0}, 32'd1);
      @(posedge clk);
      #1;
      memwrite[0] = 1'b0;
      @(negedge clk);
      chk("wst_resp_stall", {31'd0, stall0}, 32'd0);
      chk("wst_resp_rd", readdata0, 32'd9);
      chk("wst_err", {31'd0, err0}, 32'd1);
      idle(0);
      do_load(0, 32'd16, 2, 32'h16, "wst_ignored");
      idle(0);
      @(negedge clk);
      chk("hold_rd", readdata0, 32'h16);
      pulse_reset(0);

      // Table of stores/loads on the RD_LAT=2 instance.
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].ld) do_load(0, tbl[i].a, 2, tbl[i].exp_rd, $sformatf("v%0d", i));
         else do_store(0, tbl[i].a, tbl[i].wd);
         chk($sformatf("v%0d_err", i), {31'd0, err0}, {31'd0, tbl[i].e_err});
         chk($sformatf("v%0d_done", i), {31'd0, done_flag0}, {31'd0, tbl[i].e_done});
         chk($sformatf("v%0d_dval", i), done_value0, tbl[i].e_dval);
      end
      idle(0);

      // RD_LAT=1 instance: single stall cycle, back-to-back loads.
      do_store(1, 32'd0, 32'h100);
      do_store(1, 32'd4, 32'h104);
      do_load(1, 32'd0, 1, 32'h100, "l1_a");
      do_load(1, 32'd4, 1, 32'h104, "l1_b");
      do_load(1, 32'd0, 1, 32'h100, "l1_c");
      idle(1);
      @(negedge clk);
      chk("l1_err", {31'd0, err1}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Data-memory responder on the processor side of the memwrite/dataadr/writedata bus, i.e. the target the core's stores and loads land on.
- Adds configurable read wait-states with a stall handshake back to the core.
- Adds one memory-mapped "done" mailbox register, letting self-checking benches and later multicycle/pipelined cores use a real, non-ideal memory.

Parameters:
- DEPTH, 64, number of 32-bit words of RAM (word index = dataadr[31:2]).
- RD_LAT, 2, read latency in cycles; legal range 1..15.
- MMIO_ADDR, 84, byte address of the done mailbox; word-aligned, outside RAM range is not required.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- memread  in  1  load request; held by core while stall=1.
- memwrite  in  1  store request, single cycle.
- dataadr  in  32  byte address.
- writedata  in  32  store data.
- readdata  out  32  load data, valid in RESP cycle.
- stall  out  1  core must freeze and hold request signals while high.
- done_flag  out  1  sticky, set by any store to MMIO_ADDR.
- done_value  out  32  data of most recent store to MMIO_ADDR.
- err  out  1  sticky protocol/alignment error.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, readdata=0, stall=0, done_flag=0, done_value=0, err=0.
  - RAM contents are not cleared.
  - Reset mid-read abandons the read; no RESP is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - memwrite=1, memread=0: store commits at this edge; stall=0.
  - memread=1, memwrite=0: stall=1 combinationally this cycle, counter loads RD_LAT-1.
    - RD_LAT=1: go to RESP.
    - Otherwise: go to WAIT.
- WAIT: stall=1; counter decrements each edge; at counter==1 go to RESP.
- Load latency: cycles 0..RD_LAT-1 stall=1; cycle RD_LAT is RESP.
- RESP:
  - stall=0.
  - readdata is registered, sampled from the address latched in IDLE.
  - Next edge returns to IDLE unconditionally.
  - Core advancing and presenting a new load in the following cycle starts a fresh request.
- readdata holds its last value outside RESP.
- Address decode (applies to both loads and stores):
  - dataadr==MMIO_ADDR: store sets done_flag=1 and done_value=writedata; load returns done_value. Takes precedence over RAM.
  - Word index < DEPTH: RAM access.
  - Otherwise: store ignored; load returns 0; err not set.
  - dataadr[1:0]!=0: err=1; store ignored; load still completes its full latency and returns 0.
- Simultaneous memread & memwrite in IDLE:
  - The store is performed and the read is dropped.
  - stall=0, err=1.
- memwrite asserted during WAIT/RESP: ignored (protocol violation), err=1.
- err and done_flag clear only on reset.
- Address and request are sampled only in IDLE; changes during WAIT do not affect the returned data.

Test Plan:
- Reset released at 22 ns (10 ns clock): all outputs 0, state IDLE; assert reset low mid-WAIT → stall drops to 0 immediately, readdata unchanged.
- Store 7 to dataadr 8, then load dataadr 8 with RD_LAT=2 → stall=1 for exactly 2 cycles, RESP cycle readdata=7, stall=0.
- Store 7 to dataadr 84 → next cycle done_flag=1, done_value=7; load 84 → readdata=7; a subsequent store 5 to 80 leaves done_value=7.
- Store 0x12345678 to dataadr 6 (misaligned) → err=1, word at 4 unchanged; load 6 → after 2 stall cycles readdata=0.
- memread=memwrite=1 at dataadr 12 with writedata=9 → stall=0, err=1; later load 12 returns 9.
- RD_LAT=1 build: load dataadr 0 → exactly 1 stall cycle then RESP; back-to-back loads 0, 4 return correct words with no lost request.
